// File: rtl/rf_gain_apply.sv
// rf_gain_apply: Q4.12 complex gain with a 2-cycle latency; the whole pipe stalls on m_axis backpressure.
// Gains switch only between frames. Define RF_GAIN_SATCNT_EN to add the sat_count output.
module rf_gain_apply #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [GAIN_W-1:0]   gain_i,
  input  logic [GAIN_W-1:0]   gain_q,
  input  logic                gain_en,
  input  logic                gain_update,
  input  logic [2*DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                gain_pending
`ifdef RF_GAIN_SATCNT_EN
  ,
  output logic [15:0]         sat_count
`endif
);

  localparam int PW    = DATA_W + GAIN_W;
  localparam int FRAC  = 12;
  localparam int MAX_I = (1 << (DATA_W - 1)) - 1;
  localparam logic signed [PW:0]   MAX_V = (PW+1)'(MAX_I);
  localparam logic signed [PW:0]   MIN_V = (PW+1)'(-MAX_I - 1);
  localparam logic signed [PW:0]   HALF  = (PW+1)'(1 << (FRAC - 1));
  localparam logic [GAIN_W-1:0]    UNITY = GAIN_W'(1 << FRAC);

  typedef enum logic {S_IDLE, S_IN_FRAME} state_t;

  state_t              state_q;
  logic [GAIN_W-1:0]   act_i_q, act_q_q;
  logic                gain_pending_q;

  logic                s1_vld_q, s1_last_q;
  logic signed [PW-1:0] s1_p_i_q, s1_p_q_q;
  logic                m_vld_q, m_last_q;
  logic [2*DATA_W-1:0] m_dat_q;

  logic                adv, accept, pend_any, load;
  logic signed [DATA_W-1:0] x_i, x_q;
  logic signed [GAIN_W-1:0] g_i, g_q;
  logic signed [PW-1:0] p_i_d, p_q_d;
  logic signed [PW:0]   r_i, r_q;
  logic                sat_i, sat_q;
  logic [DATA_W-1:0]   y_i, y_q;
  logic [2*DATA_W-1:0] m_dat_d;

  function automatic logic signed [PW:0] rnd(input logic signed [PW-1:0] p);
    logic signed [PW:0] pe;
    pe = {p[PW-1], p};
    return (pe + HALF) >>> FRAC;
  endfunction

  // One advance term drives both stages, so a stall freezes everything at once.
  assign adv           = !m_vld_q || m_axis_tready;
  assign s_axis_tready = adv && ARESETN;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign x_i = s_axis_tdata[DATA_W-1:0];
  assign x_q = s_axis_tdata[2*DATA_W-1:DATA_W];
  // Bypass multiplies by exactly 1.0, which rounds back to the input unchanged.
  assign g_i = gain_en ? act_i_q : UNITY;
  assign g_q = gain_en ? act_q_q : UNITY;
  assign p_i_d = PW'(x_i) * PW'(g_i);
  assign p_q_d = PW'(x_q) * PW'(g_q);

  always_comb begin
    r_i   = rnd(s1_p_i_q);
    r_q   = rnd(s1_p_q_q);
    sat_i = (r_i > MAX_V) || (r_i < MIN_V);
    sat_q = (r_q > MAX_V) || (r_q < MIN_V);
    y_i   = r_i[DATA_W-1:0];
    y_q   = r_q[DATA_W-1:0];
    if (sat_i) y_i = r_i[PW] ? MIN_V[DATA_W-1:0] : MAX_V[DATA_W-1:0];
    if (sat_q) y_q = r_q[PW] ? MIN_V[DATA_W-1:0] : MAX_V[DATA_W-1:0];
    m_dat_d = {y_q, y_i};
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_p_i_q  <= '0;
      s1_p_q_q  <= '0;
      m_vld_q   <= 1'b0;
      m_last_q  <= 1'b0;
      m_dat_q   <= '0;
    end else if (adv) begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_last_q <= s_axis_tlast;
        s1_p_i_q  <= p_i_d;
        s1_p_q_q  <= p_q_d;
      end
      m_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        m_last_q <= s1_last_q;
        m_dat_q  <= m_dat_d;
      end
    end
  end

  // Gains load only at a frame edge: idle with nothing arriving, or on the closing beat.
  assign pend_any = gain_pending_q || gain_update;
  assign load     = pend_any && (accept ? s_axis_tlast : (state_q == S_IDLE));

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q        <= S_IDLE;
      gain_pending_q <= 1'b0;
      act_i_q        <= UNITY;
      act_q_q        <= UNITY;
    end else begin
      if (accept) state_q <= s_axis_tlast ? S_IDLE : S_IN_FRAME;
      gain_pending_q <= pend_any && !load;
      if (load) begin
        act_i_q <= gain_i;
        act_q_q <= gain_q;
      end
    end
  end

`ifdef RF_GAIN_SATCNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      sat_cnt_q <= '0;
    end else if (adv && s1_vld_q && (sat_i || sat_q) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tlast  = m_last_q;
  assign gain_pending  = gain_pending_q;

endmodule
